bank_fill_ctrl: RTL and testbench

BANK_FILL_CTRL -- requirements
Module: bank_fill_ctrl

---
 rtl/bank_fill_ctrl_pkg.sv | 27 ++
 rtl/bank_hit.sv | 20 ++
 rtl/bank_fill_ctrl.sv | 151 +++++++++++++++
 tb/tb_bank_fill_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_fill_ctrl_pkg.sv
// Shared defaults, FSM encoding and bank-select helper for the bank fill controller.
package bank_fill_ctrl_pkg;

  localparam int unsigned TAG_W_DEF      = 9;
  localparam int unsigned NBANK_DEF      = 4;
  localparam int unsigned FILL_BEATS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_FILL     = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  // Lowest-index set bit wins when more than one bank matches.
  function automatic logic [1:0] lowest_bank(input logic [3:0] hits);
    logic [1:0] idx;
    idx = 2'd0;
    if (hits[0])      idx = 2'd0;
    else if (hits[1]) idx = 2'd1;
    else if (hits[2]) idx = 2'd2;
    else if (hits[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/bank_hit.sv
// Parallel tag compare: one select bit per bank whose stored tag equals the lookup tag.
module bank_hit
  import bank_fill_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NBANK = NBANK_DEF
) (
  input  logic [NBANK-1:0][TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]            i_tag,
  output logic [NBANK-1:0]            o_sel
);

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < int'(NBANK); i++) begin
      o_sel[i] = (i_tags[i] == i_tag);
    end
  end

endmodule

// File: rtl/bank_fill_ctrl.sv
// Four-bank tag directory: hit lookup, round-robin victim selection and line fill sequencing.
module bank_fill_ctrl
  import bank_fill_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W      = TAG_W_DEF,
  parameter int unsigned NBANK      = NBANK_DEF,
  parameter int unsigned FILL_BEATS = FILL_BEATS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [TAG_W-1:0]              req_tag,
  output logic                          req_ready,
  output logic                          resp_valid,
  output logic [1:0]                    resp_bank,
  output logic                          resp_was_miss,
  output logic                          mem_req_valid,
  output logic [TAG_W-1:0]              mem_req_tag,
  input  logic                          mem_req_ready,
  input  logic                          mem_data_valid,
  output logic                          fill_we,
  output logic [NBANK-1:0]              fill_bank,
  output logic [$clog2(FILL_BEATS)-1:0] fill_addr
);

  localparam int unsigned AW = $clog2(FILL_BEATS);

  state_t                      r_state;
  logic [NBANK-1:0][TAG_W-1:0] r_tags;
  logic [NBANK-1:0]            r_valid;
  logic [TAG_W-1:0]            r_tag;
  logic [1:0]                  r_ptr;
  logic [1:0]                  r_victim;
  logic [AW-1:0]               r_cnt;

  logic                        r_req_ready;
  logic                        r_resp_valid;
  logic [1:0]                  r_resp_bank;
  logic                        r_resp_was_miss;
  logic                        r_mem_req_valid;
  logic [TAG_W-1:0]            r_mem_req_tag;
  logic                        r_fill_we;
  logic [NBANK-1:0]            r_fill_bank;
  logic [AW-1:0]               r_fill_addr;

  logic [NBANK-1:0]            w_sel;
  logic [NBANK-1:0]            w_hit;

  bank_hit #(
    .TAG_W (TAG_W),
    .NBANK (NBANK)
  ) u_bank_hit (
    .i_tags (r_tags),
    .i_tag  (r_tag),
    .o_sel  (w_sel)
  );

  assign w_hit = w_sel & r_valid;

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_tags          <= '0;
      r_valid         <= '0;
      r_tag           <= '0;
      r_ptr           <= 2'd0;
      r_victim        <= 2'd0;
      r_cnt           <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_bank     <= 2'd0;
      r_resp_was_miss <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_tag   <= '0;
      r_fill_we       <= 1'b0;
      r_fill_bank     <= '0;
      r_fill_addr     <= '0;
    end else begin
      r_fill_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_tag       <= req_tag;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (|w_hit) begin
            r_resp_bank     <= lowest_bank(4'(w_hit));
            r_resp_was_miss <= 1'b0;
            r_resp_valid    <= 1'b1;
            r_state         <= ST_RESP;
          end else begin
            // Victim is dropped now so a partial fill never leaves a stale hit behind.
            r_victim         <= r_ptr;
            r_valid[r_ptr]   <= 1'b0;
            r_mem_req_valid  <= 1'b1;
            r_mem_req_tag    <= r_tag;
            r_state          <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_data_valid) begin
            r_fill_we   <= 1'b1;
            r_fill_bank <= NBANK'(1'b1) << r_victim;
            r_fill_addr <= r_cnt;
            r_cnt       <= AW'(r_cnt + 1'b1);
            if (r_cnt == AW'(FILL_BEATS - 1)) begin
              r_tags[r_victim]  <= r_tag;
              r_valid[r_victim] <= 1'b1;
              r_ptr             <= 2'(r_ptr + 2'd1);
              r_resp_bank       <= r_victim;
              r_resp_was_miss   <= 1'b1;
              r_resp_valid      <= 1'b1;
              r_state           <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          r_resp_valid    <= 1'b0;
          r_resp_was_miss <= 1'b0;
          r_req_ready     <= 1'b1;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_bank     = r_resp_bank;
  assign resp_was_miss = r_resp_was_miss;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_tag   = r_mem_req_tag;
  assign fill_we       = r_fill_we;
  assign fill_bank     = r_fill_bank;
  assign fill_addr     = r_fill_addr;

endmodule

// File: tb/tb_bank_fill_ctrl.sv
// Directed bench for bank_fill_ctrl: acts as requester and memory, checks hand-computed expectations.
module tb_bank_fill_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [8:0] req_tag;
  logic       req_ready;
  logic       resp_valid;
  logic [1:0] resp_bank;
  logic       resp_was_miss;
  logic       mem_req_valid;
  logic [8:0] mem_req_tag;
  logic       mem_req_ready;
  logic       mem_data_valid;
  logic       fill_we;
  logic [3:0] fill_bank;
  logic [3:0] fill_addr;

  int tests;
  int fails;

  typedef struct {
    bit         acc_ready;
    bit         got;
    int         lat;
    logic [1:0] bank;
    logic       was_miss;
    bit         saw_mreq;
    logic [8:0] mreq_tag;
    bit         mreq_unstable;
    int         fills;
    bit         addr_ok;
    logic [3:0] fbank;
    bit         fbank_ok;
    int         ready_while_valid;
  } obs_t;

  bank_fill_ctrl #(
    .TAG_W      (9),
    .NBANK      (4),
    .FILL_BEATS (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_bank      (resp_bank),
    .resp_was_miss  (resp_was_miss),
    .mem_req_valid  (mem_req_valid),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_data_valid (mem_data_valid),
    .fill_we        (fill_we),
    .fill_bank      (fill_bank),
    .fill_addr      (fill_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; mem_req_ready = 1'b0; mem_data_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // One request end to end; the bench plays a memory with a programmable accept delay and beat pattern.
  task automatic run_req(input logic [8:0] tag, input int wait_n, input bit toggle, input bit spurious,
                         input bit hold, input int abort_beats, output obs_t o);
    bit hs_done, hs_next;
    int mcnt, beats, phase;
    o = '{default: 0};
    o.addr_ok = 1'b1; o.fbank_ok = 1'b1;
    hs_done = 0; hs_next = 0; mcnt = 0; beats = 0; phase = 0;
    req_valid = 1'b1; req_tag = tag;
    o.acc_ready = req_ready;
    tick();
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (req_valid && req_ready) o.ready_while_valid++;
      if (mem_req_valid) begin
        if (!o.saw_mreq) begin o.saw_mreq = 1; o.mreq_tag = mem_req_tag; end
        else if (mem_req_tag !== o.mreq_tag) o.mreq_unstable = 1;
      end else if (o.saw_mreq && !hs_done) o.mreq_unstable = 1;
      if (fill_we) begin
        if (fill_addr !== 4'(o.fills)) o.addr_ok = 0;
        if (o.fills == 0) o.fbank = fill_bank;
        else if (fill_bank !== o.fbank) o.fbank_ok = 0;
        o.fills++;
      end
      if (resp_valid) begin
        o.got = 1; o.lat = c; o.bank = resp_bank; o.was_miss = resp_was_miss;
        mem_data_valid = 1'b0; mem_req_ready = 1'b0;
        return;
      end
      if (hs_done) begin
        if (beats == abort_beats) begin mem_data_valid = 1'b0; mem_req_ready = 1'b0; return; end
        mem_data_valid = (beats < 16) && (!toggle || (phase % 2 == 0));
        if (mem_data_valid) beats++;
        phase++;
      end else begin
        mem_data_valid = spurious;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid && !hs_done) begin
        mcnt++;
        if (mcnt > wait_n) begin mem_req_ready = 1'b1; hs_next = 1; end
      end
      tick();
      if (hs_next) hs_done = 1;
    end
    mem_data_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; mem_req_ready = 1'b0; mem_data_valid = 1'b0;
    tick(); tick();
    tests++; if ({req_ready, resp_valid, mem_req_valid, fill_we, resp_was_miss} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl: got %b exp 10000", {req_ready, resp_valid, mem_req_valid, fill_we, resp_was_miss}); end
    tests++; if ({resp_bank, fill_bank, fill_addr, mem_req_tag} !== 19'h0) begin
      fails++; $display("FAIL reset_data: got %h exp 0", {resp_bank, fill_bank, fill_addr, mem_req_tag}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_miss();
    obs_t o;
    run_req(9'h000, 0, 0, 0, 0, 99, o);
    tests++; if (o.acc_ready !== 1'b1) begin fails++; $display("FAIL miss0_ready: got %b exp 1", o.acc_ready); end
    tests++; if (o.got !== 1'b1) begin fails++; $display("FAIL miss0_resp: got %b exp 1", o.got); end
    tests++; if (o.lat !== 19) begin fails++; $display("FAIL miss0_lat: got %0d exp 19", o.lat); end
    tests++; if (o.saw_mreq !== 1'b1 || o.mreq_tag !== 9'h000) begin
      fails++; $display("FAIL miss0_mreq: got %b/%h exp 1/000", o.saw_mreq, o.mreq_tag); end
    tests++; if (o.fills !== 16) begin fails++; $display("FAIL miss0_fills: got %0d exp 16", o.fills); end
    tests++; if (o.addr_ok !== 1'b1) begin fails++; $display("FAIL miss0_addr_seq: got %b exp 1", o.addr_ok); end
    tests++; if (o.fbank !== 4'b0001 || o.fbank_ok !== 1'b1) begin
      fails++; $display("FAIL miss0_fill_bank: got %b/%b exp 0001/1", o.fbank, o.fbank_ok); end
    tests++; if (o.bank !== 2'd0 || o.was_miss !== 1'b1) begin
      fails++; $display("FAIL miss0_resp_fields: got %0d/%b exp 0/1", o.bank, o.was_miss); end
    tick();
  endtask

  task automatic test_fill_banks();
    obs_t o;
    logic [8:0] tags [4];
    tags[0] = 9'h011; tags[1] = 9'h022; tags[2] = 9'h033; tags[3] = 9'h044;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_req(tags[i], 0, 0, 0, 0, 99, o);
      tests++; if (o.got !== 1'b1 || o.was_miss !== 1'b1 || o.bank !== 2'(i)) begin
        fails++; $display("FAIL fill%0d_resp: got %b/%b/%0d exp 1/1/%0d", i, o.got, o.was_miss, o.bank, i); end
      tests++; if (o.fbank !== 4'(1 << i) || o.fills !== 16) begin
        fails++; $display("FAIL fill%0d_bank: got %b/%0d exp %b/16", i, o.fbank, o.fills, 4'(1 << i)); end
      tick();
    end
  endtask

  task automatic test_hit();
    obs_t o;
    run_req(9'h033, 0, 0, 0, 0, 99, o);
    tests++; if (o.got !== 1'b1 || o.lat !== 2) begin fails++; $display("FAIL hit33_lat: got %b/%0d exp 1/2", o.got, o.lat); end
    tests++; if (o.bank !== 2'd2 || o.was_miss !== 1'b0) begin
      fails++; $display("FAIL hit33_fields: got %0d/%b exp 2/0", o.bank, o.was_miss); end
    tests++; if (o.saw_mreq !== 1'b0 || o.fills !== 0) begin
      fails++; $display("FAIL hit33_no_mem: got %b/%0d exp 0/0", o.saw_mreq, o.fills); end
    tick();
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL hit33_pulse: got %b/%b exp 0/1", resp_valid, req_ready); end
    run_req(9'h011, 0, 0, 0, 0, 99, o);
    tests++; if (o.lat !== 2 || o.bank !== 2'd0 || o.was_miss !== 1'b0) begin
      fails++; $display("FAIL hit11: got %0d/%0d/%b exp 2/0/0", o.lat, o.bank, o.was_miss); end
    tick();
  endtask

  task automatic test_wrap();
    obs_t o;
    run_req(9'h055, 0, 0, 0, 0, 99, o);
    tests++; if (o.was_miss !== 1'b1 || o.bank !== 2'd0 || o.fbank !== 4'b0001) begin
      fails++; $display("FAIL wrap55: got %b/%0d/%b exp 1/0/0001", o.was_miss, o.bank, o.fbank); end
    tick();
    run_req(9'h011, 0, 0, 0, 0, 99, o);
    tests++; if (o.was_miss !== 1'b1 || o.bank !== 2'd1 || o.fbank !== 4'b0010) begin
      fails++; $display("FAIL wrap11_remiss: got %b/%0d/%b exp 1/1/0010", o.was_miss, o.bank, o.fbank); end
    tick();
    run_req(9'h044, 0, 0, 0, 0, 99, o);
    tests++; if (o.lat !== 2 || o.bank !== 2'd3 || o.was_miss !== 1'b0) begin
      fails++; $display("FAIL wrap44_hit: got %0d/%0d/%b exp 2/3/0", o.lat, o.bank, o.was_miss); end
    tick();
  endtask

  task automatic test_mem_stall();
    obs_t o;
    run_req(9'h066, 5, 1, 1, 0, 99, o);
    tests++; if (o.got !== 1'b1 || o.lat !== 39) begin fails++; $display("FAIL stall_lat: got %b/%0d exp 1/39", o.got, o.lat); end
    tests++; if (o.mreq_unstable !== 1'b0 || o.mreq_tag !== 9'h066) begin
      fails++; $display("FAIL stall_mreq: got %b/%h exp 0/066", o.mreq_unstable, o.mreq_tag); end
    tests++; if (o.fills !== 16 || o.addr_ok !== 1'b1) begin
      fails++; $display("FAIL stall_beats: got %0d/%b exp 16/1", o.fills, o.addr_ok); end
    tests++; if (o.fbank !== 4'b0100 || o.bank !== 2'd2) begin
      fails++; $display("FAIL stall_bank: got %b/%0d exp 0100/2", o.fbank, o.bank); end
    tick();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_req(9'h077, 0, 0, 0, 1, 99, o);
    tests++; if (o.lat !== 19 || o.bank !== 2'd3 || o.was_miss !== 1'b1) begin
      fails++; $display("FAIL b2b_miss: got %0d/%0d/%b exp 19/3/1", o.lat, o.bank, o.was_miss); end
    tests++; if (o.ready_while_valid !== 0) begin
      fails++; $display("FAIL b2b_early_accept: got %0d exp 0", o.ready_while_valid); end
    tick();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after: got %b exp 1", req_ready); end
    run_req(9'h077, 0, 0, 0, 0, 99, o);
    tests++; if (o.lat !== 2 || o.bank !== 2'd3 || o.was_miss !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got %0d/%0d/%b exp 2/3/0", o.lat, o.bank, o.was_miss); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    obs_t o;
    run_req(9'h0AB, 0, 0, 0, 0, 7, o);
    tests++; if (o.fills !== 7 || o.fbank !== 4'b0001) begin
      fails++; $display("FAIL midfill_pre: got %0d/%b exp 7/0001", o.fills, o.fbank); end
    rst = 1'b1;
    #1;
    tests++; if ({req_ready, resp_valid, mem_req_valid, fill_we, resp_was_miss} !== 5'b10000) begin
      fails++; $display("FAIL midfill_rst_ctrl: got %b exp 10000", {req_ready, resp_valid, mem_req_valid, fill_we, resp_was_miss}); end
    tests++; if ({resp_bank, fill_bank, fill_addr, mem_req_tag} !== 19'h0) begin
      fails++; $display("FAIL midfill_rst_data: got %h exp 0", {resp_bank, fill_bank, fill_addr, mem_req_tag}); end
    tick();
    rst = 1'b0;
    tick();
    run_req(9'h0AB, 0, 0, 0, 0, 99, o);
    tests++; if (o.was_miss !== 1'b1 || o.bank !== 2'd0 || o.fbank !== 4'b0001 || o.mreq_tag !== 9'h0AB) begin
      fails++; $display("FAIL midfill_refill: got %b/%0d/%b/%h exp 1/0/0001/0ab", o.was_miss, o.bank, o.fbank, o.mreq_tag); end
    tick();
    run_req(9'h000, 0, 0, 0, 0, 99, o);
    tests++; if (o.was_miss !== 1'b1 || o.bank !== 2'd1 || o.saw_mreq !== 1'b1) begin
      fails++; $display("FAIL midfill_tag0: got %b/%0d/%b exp 1/1/1", o.was_miss, o.bank, o.saw_mreq); end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_miss();
    test_fill_banks();
    test_hit();
    test_wrap();
    test_mem_stall();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
